// File: rtl/pipeline_hazard_irq_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / interrupt controller.
// Optional build macro IRQ_VECTORED_EN is consumed by the top module.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ISR  = 2'b10
  } irq_state_t;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  // Interrupt-id width; a single line still needs one bit
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_irq_ctrl_if.sv
// Pipeline-side bundle for the hazard / interrupt controller.
// master = pipeline (drives stage info), slave = controller.
interface pipeline_hazard_irq_ctrl_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_IRQ = 4
);
  import pipe_ctrl_pkg::*;

  localparam int unsigned IDW = id_width(NUM_IRQ);

  logic [REG_AW-1:0]  rs1_d, rs2_d, rs1_e, rs2_e;
  logic [REG_AW-1:0]  rd_e, rd_m, rd_w;
  logic               regwrite_m, regwrite_w;
  logic [1:0]         resultsrc_e;
  logic               pcsrc_e;
  logic               valid_e;
  logic [XLEN-1:0]    pc_e;
  logic               mret_e;
  logic               irq_glb_en;
  logic [NUM_IRQ-1:0] irq;

  fwd_sel_t           forwarda_e, forwardb_e;
  logic               stall_f, stall_d;
  logic               flush_d, flush_e;
  logic               trap_redirect;
  logic [XLEN-1:0]    trap_pc;
  logic [XLEN-1:0]    mepc;
  logic [IDW-1:0]     irq_id;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               irq_active;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output regwrite_m, regwrite_w, resultsrc_e, pcsrc_e, valid_e, pc_e,
    output mret_e, irq_glb_en, irq,
    input  forwarda_e, forwardb_e, stall_f, stall_d, flush_d, flush_e,
    input  trap_redirect, trap_pc, mepc, irq_id, irq_ack, irq_active
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  regwrite_m, regwrite_w, resultsrc_e, pcsrc_e, valid_e, pc_e,
    input  mret_e, irq_glb_en, irq,
    output forwarda_e, forwardb_e, stall_f, stall_d, flush_d, flush_e,
    output trap_redirect, trap_pc, mepc, irq_id, irq_ack, irq_active
  );

endinterface

// File: rtl/pipeline_hazard_irq_ctrl_irq_prio_enc.sv
// Fixed-priority encoder over pending interrupt lines; lowest index wins.
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDW     = 2
) (
  input  logic [NUM_IRQ-1:0] pending,
  output logic               any,
  output logic [IDW-1:0]     winner,
  output logic [NUM_IRQ-1:0] onehot
);

  // Scan high to low so the lowest set index is written last
  always_comb begin
    any    = |pending;
    winner = '0;
    onehot = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        winner = IDW'(i);
        onehot = NUM_IRQ'(1) << i;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_irq_ctrl.sv
// Hazard unit (forwarding, load-use stall, branch flush) with prioritised interrupt entry/MRET return.
// Build macro IRQ_VECTORED_EN: per-line trap vectors at VEC_BASE + 4*id; otherwise a single vector.
module pipeline_hazard_irq_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     REG_AW   = 5,
  parameter int unsigned     NUM_IRQ  = 4,
  parameter logic [XLEN-1:0] VEC_BASE = XLEN'(32'h0000_0100)
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_hazard_irq_ctrl_if.slave   bus
);

  localparam int unsigned IDW = id_width(NUM_IRQ);

  irq_state_t         state, state_nxt;
  logic [NUM_IRQ-1:0] pending, irq_q, onehot;
  logic               any;
  logic [IDW-1:0]     winner;
  logic               loaduse, take, mret_ret;
  logic [XLEN-1:0]    vec_pc;

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_prio_enc (
    .pending (pending),
    .any     (any),
    .winner  (winner),
    .onehot  (onehot)
  );

  // Operand forwarding: youngest producer (M) beats W; x0 never forwards
  always_comb begin
    bus.forwarda_e = FWD_RF;
    bus.forwardb_e = FWD_RF;
    if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == bus.rs1_e)      bus.forwarda_e = FWD_M;
    else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == bus.rs1_e) bus.forwarda_e = FWD_W;
    if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == bus.rs2_e)      bus.forwardb_e = FWD_M;
    else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == bus.rs2_e) bus.forwardb_e = FWD_W;
  end

  assign loaduse  = (bus.resultsrc_e == RESULTSRC_LOAD) && (bus.rd_e != '0) &&
                    ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));
  assign mret_ret = (state == ISR) && bus.mret_e && bus.valid_e;
  assign take     = (state != ISR) && any && bus.irq_glb_en && bus.valid_e &&
                    !bus.pcsrc_e && !loaduse && !bus.mret_e;

`ifdef IRQ_VECTORED_EN
  assign vec_pc = VEC_BASE + XLEN'({winner, 2'b00});
`else
  assign vec_pc = VEC_BASE;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state plus all combinational pipeline-control outputs
  always_comb begin
    state_nxt         = state;
    bus.stall_f       = 1'b0;
    bus.stall_d       = 1'b0;
    bus.flush_d       = 1'b0;
    bus.flush_e       = 1'b0;
    bus.trap_redirect = 1'b0;
    bus.trap_pc       = '0;
    bus.irq_ack       = '0;

    case (state)
      IDLE:    if (take) state_nxt = ISR;
               else if (any) state_nxt = WAIT;
      WAIT:    if (take) state_nxt = ISR;
               else if (!any || !bus.irq_glb_en) state_nxt = IDLE;
      ISR:     if (mret_ret) state_nxt = any ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase

    // A redirect or taken branch replaces the stalled fetch, so it drops the stall
    if (loaduse && !bus.pcsrc_e && !mret_ret) begin
      bus.stall_f = 1'b1;
      bus.stall_d = 1'b1;
      bus.flush_e = 1'b1;
    end
    if (bus.pcsrc_e || take || mret_ret) begin
      bus.flush_d = 1'b1;
      bus.flush_e = 1'b1;
    end
    if (take) begin
      bus.trap_redirect = 1'b1;
      bus.trap_pc       = vec_pc;
      bus.irq_ack       = onehot;
    end else if (mret_ret) begin
      bus.trap_redirect = 1'b1;
      bus.trap_pc       = bus.mepc;
    end
  end

  // Edge capture into pending: a new edge beats the acknowledge of the same line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= bus.irq;
      pending <= (pending & ~bus.irq_ack) | (bus.irq & ~irq_q);
    end
  end

  // E is squashed on take, so its PC is the return point
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mepc       <= '0;
      bus.irq_id     <= '0;
      bus.irq_active <= 1'b0;
    end else if (take) begin
      bus.mepc       <= bus.pc_e;
      bus.irq_id     <= winner;
      bus.irq_active <= 1'b1;
    end else if (mret_ret) begin
      bus.irq_active <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_irq_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_pipeline_hazard_irq_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_IRQ  = 4;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;
`ifdef IRQ_VECTORED_EN
  localparam bit VECT = 1'b1;
`else
  localparam bit VECT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_irq_ctrl_if #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_IRQ(NUM_IRQ)) bus ();

  pipeline_hazard_irq_ctrl #(
    .XLEN(XLEN), .REG_AW(REG_AW), .NUM_IRQ(NUM_IRQ), .VEC_BASE(VEC_BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: set of pending lines, last sampled levels, and the in-service record
  logic [NUM_IRQ-1:0] m_pend, m_prev;
  bit                 m_busy;
  logic [31:0]        m_mepc;
  int                 m_id;

  logic [NUM_IRQ-1:0] nx_pend, nx_irq;
  bit                 nx_take, nx_ret;
  logic [31:0]        nx_pc;
  int                 nx_win;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  function automatic logic [1:0] fwd_exp(input logic [REG_AW-1:0] rs);
    if (bus.regwrite_m && bus.rd_m != 0 && bus.rd_m == rs) return 2'b10;
    if (bus.regwrite_w && bus.rd_w != 0 && bus.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle_inputs();
    bus.rs1_d = '0; bus.rs2_d = '0; bus.rs1_e = '0; bus.rs2_e = '0;
    bus.rd_e = '0; bus.rd_m = '0; bus.rd_w = '0;
    bus.regwrite_m = 1'b0; bus.regwrite_w = 1'b0; bus.resultsrc_e = 2'b00;
    bus.pcsrc_e = 1'b0; bus.valid_e = 1'b0; bus.pc_e = '0; bus.mret_e = 1'b0;
    bus.irq_glb_en = 1'b1; bus.irq = '0;
  endtask

  // Compare every output at the falling edge, then work out the model's next state
  task automatic eval();
    int                 win;
    bit                 lu, tk, ret, stall;
    logic [31:0]        tpc;
    logic [NUM_IRQ-1:0] ack;
    @(negedge clk);
    lu  = bus.resultsrc_e == 2'b01 && bus.rd_e != 0 &&
          (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
    win = -1;
    for (int i = 0; i < int'(NUM_IRQ); i++) if (m_pend[i] && win < 0) win = i;
    tk  = !m_busy && win >= 0 && bus.irq_glb_en && bus.valid_e && !bus.pcsrc_e && !lu && !bus.mret_e;
    ret = m_busy && bus.mret_e && bus.valid_e;
    stall = lu && !bus.pcsrc_e && !ret;
    ack = '0;
    if (tk) ack[win] = 1'b1;
    tpc = tk ? VEC_BASE + (VECT ? 32'(4 * win) : 32'd0) : (ret ? m_mepc : 32'd0);

    check("forwarda_e", 64'(bus.forwarda_e), 64'(fwd_exp(bus.rs1_e)));
    check("forwardb_e", 64'(bus.forwardb_e), 64'(fwd_exp(bus.rs2_e)));
    check("stall_f", 64'(bus.stall_f), 64'(stall));
    check("stall_d", 64'(bus.stall_d), 64'(stall));
    check("flush_d", 64'(bus.flush_d), 64'(bus.pcsrc_e || tk || ret));
    check("flush_e", 64'(bus.flush_e), 64'(bus.pcsrc_e || tk || ret || stall));
    check("trap_redirect", 64'(bus.trap_redirect), 64'(tk || ret));
    check("trap_pc", 64'(bus.trap_pc), 64'(tpc));
    check("irq_ack", 64'(bus.irq_ack), 64'(ack));
    check("mepc", 64'(bus.mepc), 64'(m_mepc));
    check("irq_id", 64'(bus.irq_id), 64'(m_id));
    check("irq_active", 64'(bus.irq_active), 64'(m_busy));

    for (int i = 0; i < int'(NUM_IRQ); i++)
      nx_pend[i] = (bus.irq[i] && !m_prev[i]) ? 1'b1 : (ack[i] ? 1'b0 : m_pend[i]);
    nx_irq  = bus.irq;
    nx_take = tk;
    nx_ret  = ret;
    nx_pc   = bus.pc_e;
    nx_win  = win;
  endtask

  task automatic commit();
    @(posedge clk);
    m_pend = nx_pend;
    m_prev = nx_irq;
    if (nx_take) begin
      m_busy = 1'b1; m_mepc = nx_pc; m_id = nx_win;
    end else if (nx_ret) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic cycle();
    eval();
    commit();
  endtask

  // Asynchronous reset applied away from the clock edge; state checked while it is held
  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    m_pend = '0; m_prev = '0; m_busy = 1'b0; m_mepc = '0; m_id = 0;
    check("rst_mepc", 64'(bus.mepc), 64'd0);
    check("rst_irq_id", 64'(bus.irq_id), 64'd0);
    check("rst_irq_active", 64'(bus.irq_active), 64'd0);
    check("rst_trap_redirect", 64'(bus.trap_redirect), 64'd0);
    check("rst_irq_ack", 64'(bus.irq_ack), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    apply_reset();

    // Forwarding priority and x0
    bus.rd_m = 5'd5; bus.rd_w = 5'd5; bus.regwrite_m = 1'b1; bus.regwrite_w = 1'b1;
    bus.rs1_e = 5'd5; bus.rs2_e = 5'd0;
    eval();
    check("spec_fwd_m", 64'(bus.forwarda_e), 64'h2);
    check("spec_fwdb_x0", 64'(bus.forwardb_e), 64'h0);
    commit();
    bus.rd_m = 5'd0;
    eval();
    check("spec_fwd_w", 64'(bus.forwarda_e), 64'h1);
    commit();
    idle_inputs();

    // Load-use for one cycle
    bus.resultsrc_e = 2'b01; bus.rd_e = 5'd7; bus.rs2_d = 5'd7; bus.valid_e = 1'b1;
    eval();
    check("spec_lu_stall_f", 64'(bus.stall_f), 64'h1);
    check("spec_lu_stall_d", 64'(bus.stall_d), 64'h1);
    check("spec_lu_flush_e", 64'(bus.flush_e), 64'h1);
    commit();
    bus.resultsrc_e = 2'b00;
    eval();
    check("spec_lu_clear", 64'({bus.stall_f, bus.stall_d, bus.flush_e}), 64'h0);
    commit();

    // Single interrupt on line 2, then MRET
    bus.pc_e = 32'h40; bus.irq = 4'b0100;
    cycle();
    eval();
    check("spec_irq2_redirect", 64'(bus.trap_redirect), 64'h1);
    check("spec_irq2_pc", 64'(bus.trap_pc), VECT ? 64'h108 : 64'h100);
    check("spec_irq2_ack", 64'(bus.irq_ack), 64'h4);
    commit();
    bus.pc_e = 32'h44;
    eval();
    check("spec_irq2_mepc", 64'(bus.mepc), 64'h40);
    check("spec_irq2_id", 64'(bus.irq_id), 64'h2);
    check("spec_irq2_active", 64'(bus.irq_active), 64'h1);
    commit();
    bus.mret_e = 1'b1; bus.pc_e = 32'h200;
    eval();
    check("spec_mret_pc", 64'(bus.trap_pc), 64'h40);
    commit();
    bus.mret_e = 1'b0; bus.irq = '0;
    eval();
    check("spec_mret_inactive", 64'(bus.irq_active), 64'h0);
    commit();

    // Simultaneous lines 1 and 3: 1 first, 3 after return
    bus.irq = 4'b1010;
    cycle();
    eval();
    check("spec_two_ack1", 64'(bus.irq_ack), 64'h2);
    commit();
    cycle();
    bus.mret_e = 1'b1;
    eval();
    check("spec_two_mret_pc", 64'(bus.trap_pc), 64'h200);
    commit();
    bus.mret_e = 1'b0;
    eval();
    check("spec_two_ack3", 64'(bus.irq_ack), 64'h8);
    check("spec_two_pc3", 64'(bus.trap_pc), VECT ? 64'h10C : 64'h100);
    commit();
    bus.irq = '0;
    cycle();
    bus.mret_e = 1'b1;
    cycle();
    bus.mret_e = 1'b0;

    // Pending during a taken branch waits for the next clean cycle
    bus.irq = 4'b0001;
    cycle();
    bus.pcsrc_e = 1'b1;
    eval();
    check("spec_br_no_trap", 64'(bus.trap_redirect), 64'h0);
    check("spec_br_flush", 64'({bus.flush_d, bus.flush_e}), 64'h3);
    commit();
    bus.pcsrc_e = 1'b0;
    eval();
    check("spec_br_then_ack", 64'(bus.irq_ack), 64'h1);
    commit();

    // Reset in the middle of an ISR with another line pending
    bus.irq = 4'b1001;
    cycle();
    apply_reset();
    bus.valid_e = 1'b1;
    cycle();
    cycle();
    bus.irq = 4'b0100;
    cycle();
    eval();
    check("spec_post_rst_ack", 64'(bus.irq_ack), 64'h4);
    commit();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      bus.rs1_d = REG_AW'($urandom_range(0, 3));
      bus.rs2_d = REG_AW'($urandom_range(0, 3));
      bus.rs1_e = REG_AW'($urandom_range(0, 3));
      bus.rs2_e = REG_AW'($urandom_range(0, 3));
      bus.rd_e  = REG_AW'($urandom_range(0, 3));
      bus.rd_m  = REG_AW'($urandom_range(0, 3));
      bus.rd_w  = REG_AW'($urandom_range(0, 3));
      bus.regwrite_m  = 1'($urandom_range(0, 1));
      bus.regwrite_w  = 1'($urandom_range(0, 1));
      bus.resultsrc_e = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      bus.pcsrc_e     = ($urandom_range(0, 7) == 0);
      bus.valid_e     = ($urandom_range(0, 7) != 0);
      bus.mret_e      = ($urandom_range(0, 5) == 0);
      bus.irq_glb_en  = ($urandom_range(0, 9) != 0);
      bus.pc_e        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 5) == 0) bus.irq = bus.irq ^ NUM_IRQ'($urandom);
      if (n == 700) apply_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
